// File: rtl/nf10_pkt_rr_arbiter.sv
// nf10_pkt_rr_arbiter: packet-granular round-robin merge of NUM_PORTS AXI4-Stream
// ingress ports into one registered egress stream, with per-port enable and status.
module nf10_pkt_rr_arbiter #(
  parameter int C_S_AXIS_DATA_WIDTH  = 64,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int NUM_PORTS            = 5
) (
  input  logic                                        axi_aclk,
  input  logic                                        axi_reset,
  input  logic [NUM_PORTS*C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [NUM_PORTS*C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [NUM_PORTS*C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic [NUM_PORTS-1:0]                        s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]                        s_axis_tlast,
  output logic [NUM_PORTS-1:0]                        s_axis_tready,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]              m_axis_tdata,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]            m_axis_tkeep,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]             m_axis_tuser,
  output logic                                        m_axis_tvalid,
  output logic                                        m_axis_tlast,
  input  logic                                        m_axis_tready,
  input  logic [NUM_PORTS-1:0]                        port_enable,
  output logic [2:0]                                  cur_port,
  output logic                                        busy,
  output logic [31:0]                                 pkt_count
);

  localparam int DW = C_S_AXIS_DATA_WIDTH;
  localparam int KW = C_S_AXIS_DATA_WIDTH / 8;
  localparam int UW = C_S_AXIS_TUSER_WIDTH;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t               state_r;
  state_t               state_nxt_s;
  logic [2:0]           grant_r;
  logic [2:0]           last_grant_r;
  logic [31:0]          pkt_count_r;
  logic [NUM_PORTS-1:0] req_s;
  logic [3:0]           pick_s;
  logic                 pick_found_s;
  logic [DW-1:0]        sel_data_s;
  logic [KW-1:0]        sel_keep_s;
  logic [UW-1:0]        sel_user_s;
  logic                 sel_valid_s;
  logic                 sel_last_s;
  logic                 out_ready_s;
  logic                 accept_s;
  logic                 pkt_done_s;

  // Returns {any_request, winner}: first requester strictly after 'last', wrapping.
  function automatic logic [3:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                         input logic [2:0]           last);
    logic [2*NUM_PORTS-1:0] rot;
    logic [2:0]             pick;
    rot  = {req, req} >> ({1'b0, last} + 4'd1);
    pick = last;
    for (int j = NUM_PORTS - 1; j >= 0; j--) begin
      pick = rot[j] ? 3'((int'(last) + 1 + j) % NUM_PORTS) : pick;
    end
    return {|req, pick};
  endfunction

  assign req_s        = s_axis_tvalid & port_enable;
  assign pick_s       = rr_pick(req_s, last_grant_r);
  assign pick_found_s = pick_s[3];
  assign out_ready_s  = !m_axis_tvalid || m_axis_tready;
  assign accept_s     = (state_r == SEND) && sel_valid_s && out_ready_s;
  assign pkt_done_s   = accept_s && sel_last_s;

  assign cur_port  = grant_r;
  assign busy      = (state_r == SEND);
  assign pkt_count = pkt_count_r;

  // Select the granted port's ingress beat.
  always_comb begin
    sel_data_s  = '0;
    sel_keep_s  = '0;
    sel_user_s  = '0;
    sel_valid_s = 1'b0;
    sel_last_s  = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      sel_data_s  = (grant_r == 3'(i)) ? s_axis_tdata[i*DW +: DW] : sel_data_s;
      sel_keep_s  = (grant_r == 3'(i)) ? s_axis_tkeep[i*KW +: KW] : sel_keep_s;
      sel_user_s  = (grant_r == 3'(i)) ? s_axis_tuser[i*UW +: UW] : sel_user_s;
      sel_valid_s = (grant_r == 3'(i)) ? s_axis_tvalid[i]         : sel_valid_s;
      sel_last_s  = (grant_r == 3'(i)) ? s_axis_tlast[i]          : sel_last_s;
    end
  end

  // Ready goes back only to the granted port, combinationally from egress ready.
  always_comb begin
    s_axis_tready = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      s_axis_tready[i] = (state_r == SEND) && (grant_r == 3'(i)) && out_ready_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (pick_found_s) begin
          state_nxt_s = SEND;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SEND: begin
        if (pkt_done_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = SEND;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, grant bookkeeping and packet counter.
  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      state_r      <= IDLE;
      grant_r      <= 3'd0;
      last_grant_r <= 3'(NUM_PORTS - 1);
      pkt_count_r  <= 32'd0;
    end else begin
      state_r <= state_nxt_s;
      if ((state_r == IDLE) && pick_found_s) begin
        grant_r <= pick_s[2:0];
      end
      if (pkt_done_s) begin
        last_grant_r <= grant_r;
        pkt_count_r  <= pkt_count_r + 32'd1;
      end
    end
  end

  // Egress register: load on accept, drain on downstream ready, hold while stalled.
  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tuser  <= '0;
    end else if (accept_s) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tlast  <= sel_last_s;
      m_axis_tdata  <= sel_data_s;
      m_axis_tkeep  <= sel_keep_s;
      m_axis_tuser  <= sel_user_s;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: doc/nf10_pkt_rr_arbiter.md
# nf10_pkt_rr_arbiter

Packet-granular round-robin arbiter for the reference_nic datapath. It merges NUM_PORTS AXI4-Stream ingress streams (4 MAC ports plus the DMA TX stream) into the single stream that feeds output port lookup. Once a port is granted, the whole packet is forwarded: no interleaving, and no beat is dropped or reordered. A per-port enable mask and status outputs let the host quiesce individual ports and watch the arbiter.

## Interface
- C_S_AXIS_DATA_WIDTH, 64, TDATA width per port; TKEEP width is C_S_AXIS_DATA_WIDTH/8
- C_S_AXIS_TUSER_WIDTH, 128, TUSER width per port; passed through untouched
- NUM_PORTS, 5, number of ingress ports (2..8); port i occupies slice i of every flattened bus
- axi_aclk  in  1  single clock for all logic
- axi_reset  in  1  asynchronous, active-high reset
- s_axis_tdata  in  NUM_PORTS*C_S_AXIS_DATA_WIDTH  ingress data
- s_axis_tkeep  in  NUM_PORTS*C_S_AXIS_DATA_WIDTH/8  ingress byte enables
- s_axis_tuser  in  NUM_PORTS*C_S_AXIS_TUSER_WIDTH  ingress metadata
- s_axis_tvalid  in  NUM_PORTS  ingress valid
- s_axis_tlast  in  NUM_PORTS  ingress end of packet
- s_axis_tready  out  NUM_PORTS  ingress ready
- m_axis_tdata / m_axis_tkeep / m_axis_tuser  out  DW / DW/8 / TUW  egress beat
- m_axis_tvalid  out  1  egress valid
- m_axis_tlast  out  1  egress end of packet
- m_axis_tready  in  1  egress ready
- port_enable  in  NUM_PORTS  port may win arbitration when 1
- cur_port  out  3  index of the granted port; valid while busy=1
- busy  out  1  1 while in state SEND
- pkt_count  out  32  packets fully accepted from all ports; wraps modulo 2^32

## Operation
- State machine has two states, IDLE and SEND. Reset state is IDLE.
- IDLE:
  - Request vector req = s_axis_tvalid & port_enable.
  - If req != 0, grant the first set bit searching upward cyclically from last_grant+1. Register grant, go to SEND.
  - All s_axis_tready stay 0 in IDLE.
- SEND:
  - s_axis_tready[grant] = !m_axis_tvalid || m_axis_tready.
  - Every other s_axis_tready is 0.
  - A beat is accepted when s_axis_tvalid[grant] and s_axis_tready[grant] are both 1. The accepted beat is loaded into the output register (tdata, tkeep, tuser, tlast), and m_axis_tvalid is set.
  - When an accepted beat has tlast=1: last_grant <= grant, pkt_count increments, state goes to IDLE.
- Output register:
  - m_axis_tvalid clears when m_axis_tready=1 and no new beat is loaded in the same cycle.
  - Output contents hold while m_axis_tvalid=1 and m_axis_tready=0.
- port_enable is sampled in IDLE only. Deasserting it mid-packet does not abort the packet.
- If the granted port drops tvalid mid-packet, the arbiter stays in SEND and waits; there is no timeout.
- Single-beat packets (tlast on the first beat) are legal.

## Timing
- Reset values:
  - all s_axis_tready = 0, m_axis_tvalid = 0, m_axis_tlast = 0
  - m_axis_tdata, m_axis_tkeep, m_axis_tuser = 0
  - busy = 0, cur_port = 0, pkt_count = 0
  - last_grant = NUM_PORTS-1, so port 0 wins first.
- Arbitration takes 1 cycle (IDLE to SEND).
- First beat appears on m_axis 2 cycles after tvalid is seen in IDLE.
- Steady state is 1 beat per cycle with m_axis_tready held high.
- Between back-to-back packets there is exactly one bubble cycle (the IDLE cycle).
- Ready propagates combinationally: m_axis_tready to s_axis_tready[grant], with no extra register.
- If reset asserts mid-packet, all state clears immediately. The downstream may see a truncated packet; this is accepted behaviour.
- Reset release takes effect on the first axi_aclk edge after axi_reset falls.

## Test plan
- Single packet: port 2 sends 4 beats, DATA=0x..01..04, TKEEP=0xFF, last beat TKEEP=0x0F.
  - m_axis shows the identical 4 beats in order, first beat 2 cycles after tvalid.
  - pkt_count=1, cur_port=2 during the packet.
- All 5 ports request simultaneously from reset, 3 beats each.
  - Grant order is 0,1,2,3,4, with exactly one bubble between packets.
  - pkt_count=5.
- Random m_axis_tready (50%) on a 64-beat packet.
  - No beat lost or duplicated.
  - m_axis beats stay stable while tready=0.
  - s_axis_tready[grant] never 1 while output is full and stalled.
- port_enable=5'b11101 with ports 1 and 3 valid: only port 3 is served. Then set bit 1: port 1 is served next.
- Clear port_enable[grant] mid-packet: the packet completes intact, and that port is not granted again.
- Assert axi_reset on beat 3 of an 8-beat packet:
  - next cycle m_axis_tvalid=0, all tready=0, busy=0, pkt_count=0.
  - After release, port 0 wins first.
